// File: rtl/medidor_periodo_if.sv
// Interface between a terminal-count source and the period meter.
// The meter takes the slave side; whoever drives fim and watches the results takes master.
interface medidor_periodo_if #(
  parameter int LARGURA = 5
);
  logic               fim;
  logic [LARGURA-1:0] valor_medido;
  logic               valido;
  logic               novo;
  logic               mudou;
  logic               estouro;

  modport master (
    output fim,
    input  valor_medido, valido, novo, mudou, estouro
  );

  modport slave (
    input  fim,
    output valor_medido, valido, novo, mudou, estouro
  );
endinterface

// File: rtl/medidor_periodo.sv
// Recovers a counter's programmed maximum by timing the gap between fim rising edges.
// Reports interval-1 and flags new values, changed values and over-long intervals.
module medidor_periodo #(
  parameter int LARGURA = 5
) (
  input  logic              clk,
  input  logic              reset,
  medidor_periodo_if.slave  bus
);

  typedef enum logic [1:0] {
    ESPERA,
    MEDINDO,
    ESTOURO
  } estado_t;

  localparam logic [LARGURA-1:0] CNT_MAX = '1;

  estado_t            estado_q, estado_d;
  logic [LARGURA-1:0] cnt_q, cnt_d;
  logic [LARGURA-1:0] valor_q, valor_d;
  logic               valido_q, valido_d;
  logic               novo_q, novo_d;
  logic               mudou_q, mudou_d;
  logic               estouro_q, estouro_d;
  logic               fim_r_q, fim_r_d;
  logic               evento;

  assign evento = bus.fim & ~fim_r_q;

  always_comb begin
    // NOTE: every next-state value gets a default up front so no path leaves it unassigned (no latches).
    estado_d  = estado_q;
    cnt_d     = cnt_q;
    valor_d   = valor_q;
    valido_d  = valido_q;
    novo_d    = 1'b0;
    mudou_d   = 1'b0;
    estouro_d = estouro_q;
    fim_r_d   = bus.fim;

    unique case (estado_q)
      ESPERA: begin
        cnt_d = '0;
        if (evento) estado_d = MEDINDO;
      end

      MEDINDO: begin
        if (evento) begin
          valor_d  = cnt_q;
          valido_d = 1'b1;
          novo_d   = 1'b1;
          mudou_d  = valido_q && (cnt_q != valor_q);
          cnt_d    = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + LARGURA'(1);
        end else begin
          // Interval longer than the widest representable value: stale result is withdrawn.
          estado_d  = ESTOURO;
          estouro_d = 1'b1;
          valido_d  = 1'b0;
        end
      end

      ESTOURO: begin
        if (evento) begin
          estado_d  = MEDINDO;
          cnt_d     = '0;
          estouro_d = 1'b0;
        end
      end

      default: estado_d = ESPERA;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q  <= ESPERA;
      cnt_q     <= '0;
      valor_q   <= '0;
      valido_q  <= 1'b0;
      novo_q    <= 1'b0;
      mudou_q   <= 1'b0;
      estouro_q <= 1'b0;
      fim_r_q   <= 1'b1;  // fim held high through reset is not an edge
    end else begin
      estado_q  <= estado_d;
      cnt_q     <= cnt_d;
      valor_q   <= valor_d;
      valido_q  <= valido_d;
      novo_q    <= novo_d;
      mudou_q   <= mudou_d;
      estouro_q <= estouro_d;
      fim_r_q   <= fim_r_d;
    end
  end

  assign bus.valor_medido = valor_q;
  assign bus.valido       = valido_q;
  assign bus.novo         = novo_q;
  assign bus.mudou        = mudou_q;
  assign bus.estouro      = estouro_q;

endmodule

// File: tb/tb_medidor_periodo.sv
// Bench for medidor_periodo: timestamp-based reference model of fim rising edges,
// fixed scenarios plus randomized fim streams and a behavioural counter source.
module tb_medidor_periodo;
  localparam int L   = 5;
  localparam int LIM = 1 << L;

  logic clk = 1'b0;
  logic reset;
  medidor_periodo_if #(.LARGURA(L)) bus ();

  medidor_periodo #(.LARGURA(L)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: remembers when the last accepted rising edge happened.
  int n_cyc    = 0;
  int t_ref    = 0;
  bit have_ref = 1'b0;
  bit prev_fim = 1'b1;
  int m_val    = 0;
  bit m_valid  = 1'b0;
  bit m_novo   = 1'b0;
  bit m_mudou  = 1'b0;
  bit m_est    = 1'b0;

  function automatic logic [L+3:0] obs();
    return {bus.valor_medido, bus.valido, bus.novo, bus.mudou, bus.estouro};
  endfunction

  function automatic logic [L+3:0] expv();
    logic [L-1:0] v;
    v = m_val[L-1:0];
    return {v, m_valid, m_novo, m_mudou, m_est};
  endfunction

  task automatic tick(input logic f, input logic r);
    int meas;
    bus.fim = f;
    reset   = r;
    @(posedge clk);
    n_cyc++;
    if (r) begin
      have_ref = 1'b0; prev_fim = 1'b1; m_val = 0;
      m_valid = 1'b0; m_novo = 1'b0; m_mudou = 1'b0; m_est = 1'b0;
    end else begin
      m_novo  = 1'b0;
      m_mudou = 1'b0;
      if (f && !prev_fim) begin
        if (have_ref && (n_cyc - t_ref) <= LIM) begin
          meas    = n_cyc - t_ref - 1;
          m_mudou = m_valid && (meas != m_val);
          m_val   = meas;
          m_valid = 1'b1;
          m_novo  = 1'b1;
        end
        m_est    = 1'b0;
        have_ref = 1'b1;
        t_ref    = n_cyc;
      end else if (have_ref && (n_cyc - t_ref) == LIM) begin
        m_est   = 1'b1;
        m_valid = 1'b0;
      end
      prev_fim = f;
    end
    #1;
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    n_total++;
    if (obs() !== '0) $display("FAIL reset_state: got %b expected %b", obs(), {(L+4){1'b0}});
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0);
      n_total++;
      if (obs() !== expv()) $display("FAIL reset_fim_high: got %b expected %b", obs(), expv());
      else n_pass++;
    end
    tick(1'b0, 1'b0);
  endtask

  task automatic test_periodo_fixo();
    for (int p = 0; p < 6; p++) begin
      if (p > 0) begin
        for (int c = 0; c < 3; c++) begin
          tick(1'b0, 1'b0);
          n_total++;
          if (obs() !== expv()) $display("FAIL fixo_model: got %b expected %b", obs(), expv());
          else n_pass++;
        end
      end
      tick(1'b1, 1'b0);
      n_total++;
      if (p == 0) begin
        if (bus.novo !== 1'b0) $display("FAIL fixo_first_pulse: novo got %b expected 0", bus.novo);
        else n_pass++;
      end else begin
        if ({bus.valor_medido, bus.valido, bus.novo, bus.mudou} !== {L'(3), 1'b1, 1'b1, 1'b0})
          $display("FAIL fixo_pulse%0d: got v=%0d val=%b n=%b m=%b expected v=3 val=1 n=1 m=0",
                   p, bus.valor_medido, bus.valido, bus.novo, bus.mudou);
        else n_pass++;
      end
    end
  endtask

  task automatic test_mudanca_periodo();
    int gaps [3] = '{4, 12, 12};
    logic [L+1:0] want [3];
    want[0] = {L'(3),  1'b1, 1'b0};
    want[1] = {L'(11), 1'b1, 1'b1};
    want[2] = {L'(11), 1'b1, 1'b0};
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < gaps[k] - 1; c++) begin
        tick(1'b0, 1'b0);
        n_total++;
        if (obs() !== expv()) $display("FAIL mudanca_model: got %b expected %b", obs(), expv());
        else n_pass++;
      end
      tick(1'b1, 1'b0);
      n_total++;
      if ({bus.valor_medido, bus.novo, bus.mudou} !== want[k])
        $display("FAIL mudanca_gap%0d: got v=%0d n=%b m=%b expected %b", k, bus.valor_medido,
                 bus.novo, bus.mudou, want[k]);
      else n_pass++;
    end
  endtask

  task automatic test_pulso_largo();
    int novos;
    tick(1'b0, 1'b0);
    for (int p = 0; p < 5; p++) begin
      novos = 0;
      for (int c = 0; c < 8; c++) begin
        tick(c < 3, 1'b0);
        if (bus.novo === 1'b1) novos++;
        n_total++;
        if (obs() !== expv()) $display("FAIL largo_model: got %b expected %b", obs(), expv());
        else n_pass++;
        if (p >= 1 && c == 0) begin
          n_total++;
          if (bus.valor_medido !== L'(7) || bus.novo !== 1'b1)
            $display("FAIL largo_valor: got v=%0d n=%b expected v=7 n=1", bus.valor_medido, bus.novo);
          else n_pass++;
        end
      end
      n_total++;
      if (novos != 1) $display("FAIL largo_novo_count: got %0d expected 1", novos);
      else n_pass++;
    end
  endtask

  task automatic test_estouro();
    tick(1'b1, 1'b0);
    for (int i = 1; i < 32; i++) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    n_total++;
    if ({bus.valor_medido, bus.valido, bus.novo} !== {L'(31), 1'b1, 1'b1})
      $display("FAIL estouro_max: got v=%0d val=%b n=%b expected v=31 val=1 n=1",
               bus.valor_medido, bus.valido, bus.novo);
    else n_pass++;
    for (int i = 1; i < 40; i++) begin
      tick(1'b0, 1'b0);
      n_total++;
      if (obs() !== expv()) $display("FAIL estouro_model: got %b expected %b", obs(), expv());
      else n_pass++;
      if (i == 31 || i == 32) begin
        n_total++;
        if ({bus.estouro, bus.valido} !== ((i == 32) ? 2'b10 : 2'b01))
          $display("FAIL estouro_at%0d: got est=%b val=%b", i, bus.estouro, bus.valido);
        else n_pass++;
      end
    end
    tick(1'b1, 1'b0);
    n_total++;
    if ({bus.estouro, bus.novo, bus.valor_medido} !== {1'b0, 1'b0, L'(31)})
      $display("FAIL estouro_clear: got est=%b n=%b v=%0d expected est=0 n=0 v=31",
               bus.estouro, bus.novo, bus.valor_medido);
    else n_pass++;
    for (int i = 1; i < 10; i++) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    n_total++;
    if ({bus.valor_medido, bus.valido, bus.novo} !== {L'(9), 1'b1, 1'b1})
      $display("FAIL estouro_recover: got v=%0d val=%b n=%b expected v=9 val=1 n=1",
               bus.valor_medido, bus.valido, bus.novo);
    else n_pass++;
  endtask

  task automatic test_reset_meio();
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    n_total++;
    if (obs() !== '0) $display("FAIL midreset_state: got %b expected all zero", obs());
    else n_pass++;
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    n_total++;
    if (bus.novo !== 1'b0) $display("FAIL midreset_first: novo got %b expected 0", bus.novo);
    else n_pass++;
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    n_total++;
    if ({bus.valor_medido, bus.valido, bus.novo, bus.mudou} !== {L'(6), 1'b1, 1'b1, 1'b0})
      $display("FAIL midreset_second: got v=%0d val=%b n=%b m=%b expected v=6 val=1 n=1 m=0",
               bus.valor_medido, bus.valido, bus.novo, bus.mudou);
    else n_pass++;
  endtask

  task automatic test_aleatorio();
    int dens [4] = '{3, 20, 50, 90};
    int d;
    for (int b = 0; b < 8; b++) begin
      d = dens[$urandom_range(0, 3)];
      for (int c = 0; c < 60; c++) begin
        tick($urandom_range(0, 99) < d, $urandom_range(0, 199) == 0);
        n_total++;
        if (obs() !== expv()) $display("FAIL random_model: got %b expected %b", obs(), expv());
        else n_pass++;
      end
    end
  endtask

  task automatic test_contador();
    int vm, cnt_c, n_clean;
    bit changed, had_edge;
    logic f;
    cnt_c = 0; n_clean = 0; changed = 1'b1; had_edge = 1'b0; vm = 10;
    for (int draw = 0; draw < 40; draw++) begin
      vm      = $urandom_range(10, 20);
      changed = 1'b1;
      for (int c = 0; c < vm + 5; c++) begin
        f = (cnt_c >= vm);
        tick(f, 1'b0);
        n_total++;
        if (obs() !== expv()) $display("FAIL contador_model: got %b expected %b", obs(), expv());
        else n_pass++;
        if (f) begin
          if (had_edge && !changed) begin
            n_clean++;
            n_total++;
            if (bus.valor_medido !== L'(vm) || bus.novo !== 1'b1)
              $display("FAIL contador_valor: got v=%0d n=%b expected v=%0d n=1",
                       bus.valor_medido, bus.novo, vm);
            else n_pass++;
          end
          had_edge = 1'b1;
          changed  = 1'b0;
          cnt_c    = 0;
        end else begin
          cnt_c++;
        end
      end
    end
    n_total++;
    if (n_clean < 10) $display("FAIL contador_clean_intervals: got %0d expected at least 10", n_clean);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_periodo_fixo();
    test_mudanca_periodo();
    test_pulso_largo();
    test_estouro();
    test_reset_meio();
    test_aleatorio();
    test_contador();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/medidor_periodo.md
Name: medidor_periodo

Overview:
- Receiver end of the `contador` terminal-count interface.
- Watches the `fim` pulse stream from a `contador` instance and recovers the `valor_maximo` that the counter was programmed with.
- The counter pulses `fim` every `valor_maximo`+1 cycles; this block measures the cycles between consecutive `fim` rising edges and reports interval−1.
- Also flags updates, value changes, and intervals too long to represent.
- Sits next to `contador` in the `contador_semaforo1_detectapadrao` subsystem, as its self-check and monitor.

Parameters:
- LARGURA, 5: width of the measured value. Largest representable value is 2**LARGURA−1.

Ports:
- clk, input, 1: system clock. Every register updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- fim, input, 1: terminal-count signal from the counter. Any level duration is accepted.
- valor_medido, output, LARGURA: last completed measurement, equal to rising-edge interval − 1.
- valido, output, 1: high when valor_medido holds a measurement that is still current.
- novo, output, 1: one-cycle pulse on the edge where valor_medido is written.
- mudou, output, 1: one-cycle pulse, coincident with novo, when the new value differs from the previous valid value.
- estouro, output, 1: high while the current interval has exceeded 2**LARGURA cycles.

Behaviour:
- Edge detect:
  - fim_r is a register holding the previous fim sample.
  - evento = fim & ~fim_r. It is a single-cycle event, even if fim stays high for many cycles.
  - fim_r resets to 1, so a fim held high through reset is not treated as an edge.
- Internal counter: cnt, LARGURA bits.
- States: ESPERA, MEDINDO, ESTOURO.
- ESPERA (reset state):
  - cnt is held at 0.
  - evento → MEDINDO with cnt<=0. No output update on this transition.
- MEDINDO:
  - evento → valor_medido<=cnt, valido<=1, novo<=1, cnt<=0. State stays MEDINDO.
  - mudou<=1 only if valido was already 1 and cnt≠valor_medido.
  - No evento and cnt<2**LARGURA−1 → cnt<=cnt+1.
  - No evento and cnt==2**LARGURA−1 → ESTOURO, with estouro<=1 and valido<=0. valor_medido keeps its old value.
- ESTOURO:
  - cnt is frozen.
  - evento → MEDINDO with cnt<=0 and estouro<=0. novo stays 0, because the interval that just ended is not a measurement.
- Timing example:
  - evento at edge k, next evento at edge k+P, with P ≤ 2**LARGURA.
  - At edge k+P, valor_medido becomes P−1. Outputs are visible after edge k+P, i.e. one cycle after fim is seen high.
- Extremes:
  - Minimum measurable value is 1, from fim toggling every cycle.
  - A counter programmed with valor_maximo=0 holds fim permanently high. This produces no further edges, and the block reaches ESTOURO.
- All outputs are registered. novo and mudou default to 0 on every cycle in which they are not set.
- Reset (also mid-operation):
  - valor_medido=0, valido=0, novo=0, mudou=0, estouro=0, cnt=0, fim_r=1, state ESPERA.
  - Any partial interval is discarded.
- Period change on the source: the interval that spans the change is measured as it actually occurs. The next interval reflects the new period.

Test Plan:
1. Reset, then a one-cycle fim pulse every 4 cycles (valor_maximo=3) → no novo after the 1st pulse. After the 2nd pulse: valor_medido=3, valido=1, novo=1 for one cycle, mudou=0. Every later pulse: novo=1, mudou=0.
2. Drive the period at 4 until valid, then switch to 12 → the next clean interval gives valor_medido=11 with novo=1 and mudou=1. The following interval gives valor_medido=11 with mudou=0.
3. fim high for 3 cycles, repeating every 8 cycles → valor_medido=7. Exactly one novo per period.
4. LARGURA=5: one pulse, then a gap of 32 cycles → valor_medido=31, valido=1. Then a gap of 40 cycles → estouro=1 and valido=0 exactly 32 cycles after the last edge. The next pulse clears estouro with no novo. The pulse after that gives a valid measurement.
5. Assert reset for 1 cycle mid-interval with valido=1 → all outputs are 0 on the next cycle. The first post-reset pulse produces no novo. The second post-reset pulse produces a correct measurement.
6. Connect to a `contador` instance with `valor_maximo` drawn at random from [10, 20], held for `valor_maximo`+5 cycles each draw → after each interval that does not span a change, valor_medido equals the programmed `valor_maximo`.
